dev_timer: RTL and testbench
============================

DEV_TIMER -- requirements
Module: dev_timer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port sel, input, 1 bit: device-select (hit) from the system bridge.
REQ-004 SHALL have port add, input, 32 bits: byte address; only add[3:2] is decoded.
REQ-005 SHALL have port we, input, 1 bit: write enable, qualified by sel.
REQ-006 SHALL have port wd, input, 32 bits: write data.
REQ-007 SHALL have port rd, output, 32 bits: read data, combinational.
REQ-008 SHALL have port irq, output, 1 bit: interrupt request to the CPU.

Function
REQ-009 SHALL decode registers as follows: add[3:2]=0 CTRL (read/write); 1 PRESET (read/write); 2 COUNT (read-only); 3 unmapped.
REQ-010 SHALL define CTRL fields as: bit0 EN; bits2:1 MODE; bit3 IM (interrupt mask). Bits 31:4 SHALL read as 0, and writes to them SHALL be ignored.
REQ-011 SHALL perform a register write at the clk edge where sel=1 and we=1; writes to COUNT or offset 0xC SHALL have no effect.
REQ-012 SHALL drive rd combinationally from the register selected by add[3:2], independent of sel. Offset 0xC SHALL read as 0.
REQ-013 SHALL implement FSM states IDLE, LOAD, CNT and INT.
REQ-014 IDLE: SHALL go to LOAD if EN=1; otherwise SHALL stay in IDLE, with COUNT held.
REQ-015 LOAD: SHALL load COUNT with PRESET and go to CNT.
REQ-016 CNT: if EN=0, SHALL go to IDLE with COUNT held; else if COUNT>1, SHALL decrement COUNT and stay; else SHALL set COUNT to 0 and go to INT.
REQ-017 INT, MODE=0: SHALL clear EN, set irq_flag and go to IDLE. irq_flag SHALL stay set until the next CPU write to CTRL or PRESET.
REQ-018 INT, MODE=1: SHALL go to IDLE with EN kept, so the timer auto-reloads. irq_flag SHALL be high only while state=INT (one-cycle pulse).
REQ-019 MODE values 2 and 3 SHALL behave as MODE=0.
REQ-020 irq SHALL equal IM AND irq_flag; it SHALL be a registered/state-derived signal with no combinational path from bus inputs.
REQ-021 Timing, PRESET=N>=1, EN written at edge E0: state LOAD after E1, CNT with COUNT=N after E2, INT with COUNT=0 after E(N+2); irq SHALL be high after E(N+2).
REQ-022 The MODE=1 interrupt period SHALL be N+3 cycles.
REQ-023 PRESET=0 SHALL behave as PRESET=1: COUNT=0 in CNT, and INT on the next edge.
REQ-024 A PRESET write during CNT SHALL NOT alter the running COUNT; it SHALL take effect at the next LOAD.
REQ-025 A simultaneous CPU write to CTRL and the INT-state EN clear (MODE=0) SHALL resolve in favour of the CPU write value.
REQ-026 A CPU write to CTRL or PRESET on the same edge as INT entry in MODE=0 SHALL leave irq_flag set; the set takes priority over the clear.
REQ-027 COUNT SHALL be 32 bits and SHALL never wrap below 0.

Reset
REQ-028 On reset=1 at a clk edge, CTRL, PRESET, COUNT and irq_flag SHALL be set to 0 and state to IDLE, so irq=0 and rd reads 0 for all offsets.
REQ-029 Reset SHALL override any simultaneous bus write and SHALL abort an in-progress count in any state.

Verification
REQ-030 Reset, then read offsets 0x0/0x4/0x8/0xC -> rd=0 for each; irq=0.
REQ-031 Write PRESET=3, then CTRL=0x9 (EN, MODE0, IM) -> COUNT reads 3,2,1,0 on successive cycles; irq rises 5 edges after the CTRL write and stays high; CTRL reads 0x8; a write of CTRL=0x8 clears irq.
REQ-032 PRESET=2, CTRL=0xB (MODE1, IM) -> irq is a one-cycle pulse every 5 cycles; EN stays 1; a write of CTRL=0x0 mid-count freezes COUNT and stops pulses.
REQ-033 CTRL=0x1 (IM=0), PRESET=1 -> count completes, irq stays 0, and setting IM=1 afterwards by writing CTRL=0x8 clears the flag, so irq stays 0.
REQ-034 Write COUNT=0x1234 and offset 0xC -> COUNT unchanged; a PRESET write of 7 during CNT leaves the current countdown intact, and the next reload starts at 7.
REQ-035 Assert reset while in CNT with COUNT=5 -> the next cycle shows state IDLE, COUNT=0, irq=0, CTRL=0.

Source files
------------

// File: rtl/dev_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload
// operation, maskable interrupt.
module dev_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] add,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state_r;
    logic [3:0]  ctrl_r;
    logic [31:0] preset_r;
    logic [31:0] count_r;
    logic        irq_flag_r;

    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        mode_reload_s;
    logic        int_entry_s;
    logic        unused_add_s;

    assign wr_ctrl_s     = sel & we & (add[3:2] == 2'd0);
    assign wr_preset_s   = sel & we & (add[3:2] == 2'd1);
    assign mode_reload_s = (ctrl_r[2:1] == 2'd1);
    assign int_entry_s   = (state_r == CNT) & ctrl_r[0] & (count_r <= 32'd1);
    assign unused_add_s  = ^{add[31:4], add[1:0]};

    // Register file, countdown FSM and interrupt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            ctrl_r     <= 4'd0;
            preset_r   <= 32'd0;
            count_r    <= 32'd0;
            irq_flag_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ctrl_r[0]) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    count_r <= preset_r;
                    state_r <= CNT;
                end
                CNT: begin
                    if (!ctrl_r[0]) begin
                        state_r <= IDLE;
                    end else if (count_r > 32'd1) begin
                        count_r <= count_r - 32'd1;
                    end else begin
                        // PRESET=0 lands here too, so COUNT never wraps
                        count_r <= 32'd0;
                        state_r <= INT;
                    end
                end
                INT: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            // A CPU write to CTRL outranks the one-shot EN clear
            if (wr_ctrl_s) begin
                ctrl_r <= wd[3:0];
            end else if ((state_r == INT) && !mode_reload_s) begin
                ctrl_r[0] <= 1'b0;
            end else begin
                ctrl_r <= ctrl_r;
            end

            if (wr_preset_s) begin
                preset_r <= wd;
            end else begin
                preset_r <= preset_r;
            end

            // Entering INT sets the flag even if a clearing write lands on the same edge
            if (int_entry_s) begin
                irq_flag_r <= 1'b1;
            end else if (wr_ctrl_s || wr_preset_s) begin
                irq_flag_r <= 1'b0;
            end else if ((state_r == INT) && mode_reload_s) begin
                irq_flag_r <= 1'b0;
            end else begin
                irq_flag_r <= irq_flag_r;
            end
        end
    end

    // Read mux, independent of sel.
    always_comb begin
        rd = 32'd0;
        case (add[3:2])
            2'd0:    rd = {28'd0, ctrl_r};
            2'd1:    rd = preset_r;
            2'd2:    rd = count_r;
            default: rd = 32'd0;
        endcase
    end

    assign irq = ctrl_r[3] & irq_flag_r;

endmodule

// File: tb/tb_dev_timer.sv
// Self-checking bench for dev_timer: vector table, directed corner sequences and
// randomized traffic against a behavioural model.
module tb_dev_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] add = 32'd0;
    logic        we = 1'b0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_CNT  = 2;
    localparam int S_INT  = 3;

    logic [3:0]  m_ctrl = 4'd0;
    logic [31:0] m_preset = 32'd0;
    logic [31:0] m_count = 32'd0;
    logic        m_flag = 1'b0;
    int          m_st = S_IDLE;

    typedef struct {
        logic        s;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[16];

    dev_timer dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .add   (add),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        case (a[3:2])
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // Reference: one clock edge of the timer as the requirements describe it.
    task automatic model_step(input logic r, input logic s, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
        logic wc, wp, enter_int;
        logic [3:0] nc;
        logic [31:0] np, nn;
        logic nf;
        int ns;
        if (r) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_st = S_IDLE;
        end else begin
            wc = s && w && (a[3:2] == 2'd0);
            wp = s && w && (a[3:2] == 2'd1);
            nc = m_ctrl; np = m_preset; nn = m_count; nf = m_flag; ns = m_st;
            enter_int = 1'b0;
            case (m_st)
                S_IDLE: if (m_ctrl[0]) ns = S_LOAD;
                S_LOAD: begin nn = m_preset; ns = S_CNT; end
                S_CNT: begin
                    if (!m_ctrl[0]) ns = S_IDLE;
                    else if (m_count > 32'd1) nn = m_count - 32'd1;
                    else begin nn = 32'd0; ns = S_INT; enter_int = 1'b1; end
                end
                default: begin
                    ns = S_IDLE;
                    if (m_ctrl[2:1] == 2'd1) nf = 1'b0;
                    else nc[0] = 1'b0;
                end
            endcase
            if (wc) nc = d[3:0];
            if (wp) np = d;
            if (enter_int) nf = 1'b1;
            else if (wc || wp) nf = 1'b0;
            m_ctrl = nc; m_preset = np; m_count = nn; m_flag = nf; m_st = ns;
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
        reset = r; sel = s; we = w; add = a; wd = d;
        @(posedge clk);
        model_step(r, s, w, a, d);
        #1;
        check("model_irq", {31'd0, irq}, {31'd0, m_ctrl[3] & m_flag});
        check("model_rd", rd, m_rd(a));
        reset = 1'b0; sel = 1'b0; we = 1'b0;
    endtask

    task automatic peek(input string name, input logic [31:0] off, input logic [31:0] exp);
        add = off;
        #1;
        check(name, rd, exp);
    endtask

    initial begin
        logic [31:0] pmask;
        logic        any_irq;

        tbl[0]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 32'h4, 32'h3, 32'h3, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 32'h0, 32'hFFFF_FFF9, 32'h9, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h8, 32'h0, 32'h3, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h8, 32'h0, 32'h2, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h8, 32'h0, 32'h1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h8, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 32'h0, 32'h8, 32'h8, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h8, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0};

        // Reset overriding a simultaneous CTRL write, then the one-shot vector table
        tick(1'b1, 1'b1, 1'b1, 32'h0, 32'hF);
        check("reset_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d);
            check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
        end

        // Auto-reload: PRESET=2 pulses at edges 4, 9, 14 after the CTRL write
        tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h4, 32'h2);
        tick(1'b0, 1'b1, 1'b1, 32'h0, 32'hB);
        pmask = 32'd0;
        for (int k = 1; k <= 15; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
            if (irq) pmask[k] = 1'b1;
        end
        check("m1_pulse_edges", pmask, 32'h0000_4210);
        peek("m1_ctrl_kept", 32'h0, 32'hB);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
        any_irq = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
            any_irq |= irq;
        end
        check("m1_stop_irq", {31'd0, any_irq}, 32'd0);
        peek("m1_frozen_count", 32'h8, 32'h1);

        // Masked completion, then IM=1 write clears the hidden flag
        tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h4, 32'h1);
        tick(1'b0, 1'b1, 1'b1, 32'h0, 32'h1);
        any_irq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
            any_irq |= irq;
        end
        peek("im0_en_cleared", 32'h0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h0, 32'h8);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            any_irq |= irq;
        end
        check("im0_irq_low", {31'd0, any_irq}, 32'd0);

        // Read-only COUNT, unmapped offset, PRESET rewrite during CNT
        tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h8, 32'h1234);
        peek("count_ro", 32'h8, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'hC, 32'h55);
        peek("unmapped_count", 32'h8, 32'h0);
        peek("unmapped_rd", 32'hC, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h4, 32'h5);
        tick(1'b0, 1'b1, 1'b1, 32'h0, 32'h1);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        peek("cnt_start5", 32'h8, 32'h5);
        tick(1'b0, 1'b1, 1'b1, 32'h4, 32'h7);
        peek("cnt_intact", 32'h8, 32'h4);
        peek("preset_new", 32'h4, 32'h7);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        peek("cnt_done", 32'h8, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h0, 32'h1);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        peek("reload_7", 32'h8, 32'h7);

        // Reset in the middle of a countdown
        tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h4, 32'h5);
        tick(1'b0, 1'b1, 1'b1, 32'h0, 32'h9);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        peek("pre_rst_count", 32'h8, 32'h5);
        tick(1'b1, 1'b1, 1'b1, 32'h0, 32'hF);
        peek("rst_ctrl", 32'h0, 32'h0);
        peek("rst_count", 32'h8, 32'h0);
        peek("rst_preset", 32'h4, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        peek("rst_idle_count", 32'h8, 32'h0);

        // PRESET=0 behaves as 1
        tick(1'b0, 1'b1, 1'b1, 32'h4, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h0, 32'h9);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        check("p0_cnt_irq", {31'd0, irq}, 32'd0);
        peek("p0_count", 32'h8, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        check("p0_int_irq", {31'd0, irq}, 32'd1);

        // Same-edge collisions: flag set beats write clear; CTRL write beats EN clear
        tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h4, 32'h1);
        tick(1'b0, 1'b1, 1'b1, 32'h0, 32'h9);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h4, 32'h2);
        check("set_beats_clear", {31'd0, irq}, 32'd1);
        tick(1'b0, 1'b1, 1'b1, 32'h0, 32'h9);
        peek("cpu_beats_en_clr", 32'h0, 32'h9);
        check("write_clears_irq", {31'd0, irq}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_sel, r_we;
            logic [31:0] r_add, r_wd;
            r_rst = ($urandom_range(0, 249) == 0);
            r_sel = ($urandom_range(0, 3) != 0);
            r_we  = ($urandom_range(0, 9) == 0);
            r_add = $urandom;
            r_wd  = (r_add[3:2] == 2'd1) ? 32'($urandom_range(0, 8)) : $urandom;
            tick(r_rst, r_sel, r_we, r_add, r_wd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
